led_anim_scheduler: RTL and testbench

//  Shares the 10-LED bar between the two players' fire results. Each player requests one effect
//  (MISS / HIT / SINK); block arbitrates round-robin, plays the selected frame sequence at a

---
 rtl/led_anim_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_led_anim_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_anim_scheduler.sv
// led_anim_scheduler
//   Shares one 10-LED bar between two players' fire results. Each player
//   requests a single effect (MISS / HIT / SINK). The block picks one
//   requester round-robin, plays that effect's frame sequence with every
//   frame held for STEP_TICKS clocks, and then blanks the bar for another
//   STEP_TICKS clocks before it accepts the next request.
//
//   Optional feature macro: LED_ANIM_SINK_PRIO_EN
//     When defined, a SINK request beats a non-SINK request on contention.
//     The round-robin pointer still moves past the winner.
//     When undefined, arbitration is pure round-robin.
//
// Ports
//   clk        in   1        system clock, all logic on posedge
//   reset      in   1        synchronous active-high reset
//   req        in   2        request per player, [0]=P1 [1]=P2, held until ack
//   effect_p1  in   2        00 MISS, 01 HIT, 10 SINK, 11 treated as HIT
//   effect_p2  in   2        same encoding as effect_p1
//   ack        out  2        one-cycle grant pulse per player
//   busy       out  1        high while playing or in the blank gap
//   owner      out  1        player whose effect is (or was last) playing
//   led        out  NUM_LED  registered LED bar drive
module led_anim_scheduler #(
    parameter int STEP_TICKS = 25_000_000,
    parameter int NUM_LED    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [1:0]         effect_p1,
    input  logic [1:0]         effect_p2,
    output logic [1:0]         ack,
    output logic               busy,
    output logic               owner,
    output logic [NUM_LED-1:0] led
);

    // A single-cycle step still needs a one-bit counter to keep widths legal.
    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

    localparam logic [1:0] EFF_MISS = 2'b00;
    localparam logic [1:0] EFF_SINK = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [TW-1:0]      tick, tick_n;
    logic [3:0]         frame, frame_n;
    logic [1:0]         eff, eff_n;
    logic               rr, rr_n;
    logic [NUM_LED-1:0] led_n;
    logic [1:0]         ack_n;
    logic               busy_n;
    logic               owner_n;

    logic               grant_id;
    logic [1:0]         grant_eff;
    logic               tick_wrap;
    logic               frame_last;

    // Index of the final frame for a latched effect.
    function automatic logic [3:0] last_index(input logic [1:0] e);
        if (e == EFF_MISS)      last_index = 4'd3;
        else if (e == EFF_SINK) last_index = 4'd10;
        else                    last_index = 4'd6;
    endfunction

    // Frame ROM. SINK shares HIT's first seven frames, so only MISS needs
    // its own table; HIT never reaches indices above 6.
    function automatic logic [NUM_LED-1:0] frame_rom(input logic [1:0] e,
                                                     input logic [3:0] idx);
        logic [NUM_LED-1:0] f;
        f = '0;
        if (e == EFF_MISS) begin
            f = idx[0] ? 10'b0000000000 : 10'b0000110000;
        end else begin
            case (idx)
                4'd0:    f = 10'b0000110000;
                4'd1:    f = 10'b0011111100;
                4'd2:    f = 10'b0111001110;
                4'd3:    f = 10'b1110000111;
                4'd4:    f = 10'b1100000011;
                4'd5:    f = 10'b1000000001;
                4'd7:    f = 10'b1111111111;
                4'd9:    f = 10'b1111111111;
                default: f = 10'b0000000000;
            endcase
        end
        frame_rom = f;
    endfunction

    assign tick_wrap  = (tick == TICK_LAST);
    assign frame_last = (frame == last_index(eff));

    // Arbitration: a lone requester wins; on contention the rr pointer
    // decides, optionally overridden by SINK priority.
    always_comb begin
        grant_id = 1'b0;
        if (req[0] && req[1]) begin
            grant_id = rr;
`ifdef LED_ANIM_SINK_PRIO_EN
            if ((effect_p1 == EFF_SINK) && (effect_p2 != EFF_SINK))
                grant_id = 1'b0;
            else if ((effect_p2 == EFF_SINK) && (effect_p1 != EFF_SINK))
                grant_id = 1'b1;
`endif
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
    end

    assign grant_eff = grant_id ? effect_p2 : effect_p1;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            tick  <= '0;
            frame <= '0;
            eff   <= EFF_MISS;
            rr    <= 1'b0;
            led   <= '0;
            ack   <= 2'b00;
            busy  <= 1'b0;
            owner <= 1'b0;
        end else begin
            state <= state_n;
            tick  <= tick_n;
            frame <= frame_n;
            eff   <= eff_n;
            rr    <= rr_n;
            led   <= led_n;
            ack   <= ack_n;
            busy  <= busy_n;
            owner <= owner_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (|req) state_n = S_PLAY;
            S_PLAY: if (tick_wrap && frame_last) state_n = S_GAP;
            S_GAP:  if (tick_wrap) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        tick_n  = tick;
        frame_n = frame;
        eff_n   = eff;
        rr_n    = rr;
        led_n   = led;
        ack_n   = 2'b00;
        busy_n  = busy;
        owner_n = owner;
        case (state)
            S_IDLE: begin
                led_n  = '0;
                busy_n = 1'b0;
                if (|req) begin
                    ack_n[grant_id] = 1'b1;
                    owner_n = grant_id;
                    rr_n    = ~grant_id;
                    eff_n   = grant_eff;
                    tick_n  = '0;
                    frame_n = '0;
                    led_n   = frame_rom(grant_eff, 4'd0);
                    busy_n  = 1'b1;
                end
            end
            S_PLAY: begin
                if (tick_wrap) begin
                    tick_n = '0;
                    if (frame_last) begin
                        led_n = '0;
                    end else begin
                        frame_n = frame + 4'd1;
                        led_n   = frame_rom(eff, frame + 4'd1);
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            S_GAP: begin
                led_n = '0;
                if (tick_wrap) begin
                    tick_n = '0;
                    busy_n = 1'b0;
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            default: begin
                led_n  = '0;
                busy_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_led_anim_scheduler.sv
module tb_led_anim_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req, effect_p1, effect_p2;
    logic [1:0] ack;
    logic       busy, owner;
    logic [9:0] led;

    logic [1:0] req_b, effect_p1_b, effect_p2_b;
    logic [1:0] ack_b;
    logic       busy_b, owner_b;
    logic [9:0] led_b;

    int checks = 0;
    int errors = 0;

    logic [9:0] hit_tab [7] = '{10'b0000110000, 10'b0011111100, 10'b0111001110,
                                10'b1110000111, 10'b1100000011, 10'b1000000001,
                                10'b0000000000};

    always #5 clk = ~clk;

    led_anim_scheduler #(.STEP_TICKS(2), .NUM_LED(10)) u_dut (
        .clk(clk), .reset(reset), .req(req), .effect_p1(effect_p1),
        .effect_p2(effect_p2), .ack(ack), .busy(busy), .owner(owner), .led(led)
    );

    led_anim_scheduler #(.STEP_TICKS(1), .NUM_LED(10)) u_dut1 (
        .clk(clk), .reset(reset), .req(req_b), .effect_p1(effect_p1_b),
        .effect_p2(effect_p2_b), .ack(ack_b), .busy(busy_b), .owner(owner_b), .led(led_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 2'b00; req_b = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, want 0", busy, limit);
        end
    endtask

    task automatic test_reset();
        effect_p1 = 2'b00; effect_p2 = 2'b00;
        effect_p1_b = 2'b00; effect_p2_b = 2'b00;
        do_reset();
        checks++;
        if ({led, ack, busy, owner} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state: led=%b ack=%b busy=%b owner=%b, want all 0",
                     led, ack, busy, owner);
        end
        checks++;
        if ({led_b, ack_b, busy_b, owner_b} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state_b: led=%b ack=%b busy=%b owner=%b, want all 0",
                     led_b, ack_b, busy_b, owner_b);
        end
    endtask

    task automatic test_hit_p1();
        do_reset();
        req = 2'b01; effect_p1 = 2'b01;
        tick();
        checks++;
        if (ack !== 2'b01 || owner !== 1'b0) begin
            errors++;
            $display("FAIL hit_ack: ack=%b owner=%b, want 01/0", ack, owner);
        end
        req = 2'b00;
        for (int f = 0; f < 7; f++) begin
            for (int t = 0; t < 2; t++) begin
                checks++;
                if (led !== hit_tab[f] || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL hit_frame%0d_%0d: led=%b busy=%b, want %b/1",
                             f, t, led, busy, hit_tab[f]);
                end
                if (f != 0 || t != 0) begin
                    checks++;
                    if (ack !== 2'b00) begin
                        errors++;
                        $display("FAIL hit_ack_pulse: ack=%b, want 00", ack);
                    end
                end
                tick();
            end
        end
        for (int t = 0; t < 2; t++) begin
            checks++;
            if (led !== 10'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hit_gap%0d: led=%b busy=%b, want 0/1", t, led, busy);
            end
            tick();
        end
        checks++;
        if (led !== 10'd0 || busy !== 1'b0 || owner !== 1'b0) begin
            errors++;
            $display("FAIL hit_done: led=%b busy=%b owner=%b, want 0/0/0", led, busy, owner);
        end
    endtask

    task automatic test_rr_both();
        do_reset();
        req = 2'b11; effect_p1 = 2'b01; effect_p2 = 2'b01;
        tick();
        checks++;
        if (ack !== 2'b01 || owner !== 1'b0) begin
            errors++;
            $display("FAIL rr_first: ack=%b owner=%b, want 01/0", ack, owner);
        end
        req = 2'b10;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (busy !== 1'b1 || ack[1] !== 1'b0) begin
                errors++;
                $display("FAIL rr_wait%0d: busy=%b ack=%b, want 1/x0", i, busy, ack);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || owner !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: busy=%b owner=%b, want 0/0", busy, owner);
        end
        tick();
        checks++;
        if (ack !== 2'b10 || owner !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rr_second: ack=%b owner=%b busy=%b, want 10/1/1", ack, owner, busy);
        end
        req = 2'b00;
        wait_idle(40);
    endtask

    task automatic test_miss_step1();
        logic [9:0] exp_led [6];
        logic       exp_busy [6];
        exp_led  = '{10'b0000110000, 10'd0, 10'b0000110000, 10'd0, 10'd0, 10'd0};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        req_b = 2'b10; effect_p2_b = 2'b00;
        tick();
        checks++;
        if (ack_b !== 2'b10 || owner_b !== 1'b1) begin
            errors++;
            $display("FAIL miss_ack: ack=%b owner=%b, want 10/1", ack_b, owner_b);
        end
        req_b = 2'b00;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (led_b !== exp_led[i] || busy_b !== exp_busy[i]) begin
                errors++;
                $display("FAIL miss_cyc%0d: led=%b busy=%b, want %b/%b",
                         i, led_b, busy_b, exp_led[i], exp_busy[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 2'b01; effect_p1 = 2'b10;
        tick();
        req = 2'b00;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (led !== 10'b1111111111) begin
            errors++;
            $display("FAIL sink_frame7: led=%b, want 1111111111", led);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({led, ack, busy, owner} !== 14'd0) begin
            errors++;
            $display("FAIL abort: led=%b ack=%b busy=%b owner=%b, want all 0",
                     led, ack, busy, owner);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0 || ack !== 2'b00 || led !== 10'd0) begin
                errors++;
                $display("FAIL no_replay%0d: busy=%b ack=%b led=%b, want 0/00/0",
                         i, busy, ack, led);
            end
            tick();
        end
    endtask

    task automatic test_effect_latch();
        do_reset();
        req = 2'b01; effect_p1 = 2'b01;
        tick();
        req = 2'b00;
        tick();
        effect_p1 = 2'b10;
        for (int i = 1; i < 10; i++) tick();
        checks++;
        if (led !== 10'b1000000001) begin
            errors++;
            $display("FAIL latch_f5: led=%b, want 1000000001", led);
        end
        for (int i = 10; i < 14; i++) tick();
        checks++;
        if (led !== 10'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latch_gap: led=%b busy=%b, want 0/1 (HIT not SINK)", led, busy);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL latch_len: busy=%b, want 0 after 16 cycles", busy);
        end
    endtask

    task automatic test_sink_prio();
        logic [1:0] exp_ack1, exp_ack2;
`ifdef LED_ANIM_SINK_PRIO_EN
        exp_ack1 = 2'b10;
        exp_ack2 = 2'b01;
`else
        exp_ack1 = 2'b01;
        exp_ack2 = 2'b10;
`endif
        do_reset();
        req = 2'b11; effect_p1 = 2'b01; effect_p2 = 2'b10;
        tick();
        checks++;
        if (ack !== exp_ack1 || owner !== exp_ack1[1]) begin
            errors++;
            $display("FAIL prio_grant: ack=%b owner=%b, want %b/%b",
                     ack, owner, exp_ack1, exp_ack1[1]);
        end
        req = 2'b00;
        wait_idle(60);
        req = 2'b11; effect_p1 = 2'b01; effect_p2 = 2'b01;
        tick();
        checks++;
        if (ack !== exp_ack2) begin
            errors++;
            $display("FAIL prio_ptr: ack=%b, want %b", ack, exp_ack2);
        end
        req = 2'b00;
        wait_idle(40);
    endtask

    initial begin
        reset = 1'b1;
        req = 2'b00; effect_p1 = 2'b00; effect_p2 = 2'b00;
        req_b = 2'b00; effect_p1_b = 2'b00; effect_p2_b = 2'b00;
        #1;
        test_reset();
        test_hit_p1();
        test_rr_both();
        test_miss_step1();
        test_reset_mid();
        test_effect_latch();
        test_sink_prio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
